// File: rtl/dm_wait_responder.sv
// dm_wait_responder: data-memory responder for the single-cycle MIPS data bus.
// Answers one read/write request at a time after WAIT_CYCLES wait states using a
// req/ready handshake, and flags misaligned or out-of-range accesses on err.
// Optional byte-lane write enables are compiled in with `define DM_BYTE_LANES_EN.
module dm_wait_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
`ifdef DM_BYTE_LANES_EN
   input  logic [3:0]  be,
`endif
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
   // Counter load value; with zero wait states the counter is never consulted.
   localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] mem [DEPTH_WORDS];

   // Request that completes on the edge entering RESP: the live bus when coming
   // straight from IDLE (zero wait states), otherwise the captured copy.
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_be;
   logic [29:0] index_full;
   logic [AW-1:0] idx;
   logic        range_err;
   logic        align_err;
   logic        acc_err;
   logic        commit;

   assign cur_we    = (state == IDLE) ? we    : cap_we;
   assign cur_addr  = (state == IDLE) ? addr  : cap_addr;
   assign cur_wdata = (state == IDLE) ? wdata : cap_wdata;

`ifdef DM_BYTE_LANES_EN
   logic [3:0] cap_be;
   assign cur_be    = (state == IDLE) ? be : cap_be;
   // Byte lanes make sub-word addresses legal; only the range is checked.
   assign align_err = 1'b0;
`else
   assign cur_be    = 4'hF;
   assign align_err = (cur_addr[1:0] != 2'b00);
`endif

   // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
   assign index_full = 30'((cur_addr - BASE_ADDR) >> 2);
   assign idx        = index_full[AW-1:0];
   assign range_err  = (index_full >= DEPTH_LIM);
   assign acc_err    = range_err | align_err;

   // RESP always returns to IDLE, so a next state of RESP means "entering RESP".
   assign commit = (state_next == RESP);
   assign ready  = (state == RESP);

   // Next-state and wait-counter logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               cnt_next   = CNT_LOAD;
               state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_next = RESP;
            else             cnt_next   = cnt - 4'd1;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, counter, captured request and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
`ifdef DM_BYTE_LANES_EN
         cap_be    <= 4'd0;
`endif
         rdata     <= 32'd0;
         err       <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (state == IDLE && req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
`ifdef DM_BYTE_LANES_EN
            cap_be    <= be;
`endif
         end
         if (commit) begin
            err <= acc_err;
            if (acc_err)     rdata <= 32'd0;
            else if (cur_we) rdata <= cur_wdata;
            else             rdata <= mem[idx];
         end
      end
   end

   // Word storage, never reset; writes land on the edge entering RESP and are
   // suppressed while reset is held so an aborted request is never committed.
   always_ff @(posedge clk) begin
      if (rst_n && commit && cur_we && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) mem[idx][b*8 +: 8] <= cur_wdata[b*8 +: 8];
         end
      end
   end

endmodule
